// File: rtl/mixcol_seq_pkg.sv
// Purpose: shared types, widths and GF(2^8) helpers for the column-serial MixColumns sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, AES width constants, reduction constant, xtime and gf_mul.
package aes_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mix_state_e;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;
  localparam int NCOL    = 4;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [BYTE_W-1:0] GF_RED = 8'h1B;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b the unused partial products fold away.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] t;
    logic [BYTE_W-1:0] bb;
    p  = '0;
    t  = a;
    bb = b;
    for (int i = 0; i < BYTE_W; i++) begin
      if (bb[0]) p = p ^ t;
      t  = xtime(t);
      bb = bb >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/mixcol_seq_if.sv
// Purpose: input/output handshake bundle of the MixColumns sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Signals: in_valid, in_ready, Shift_Text, in_bypass, in_inv (MIXCOL_INV_EN only),
//          out_valid, out_ready, Mix_Text, busy. Slave modport is the sequencer side.
interface mixcol_seq_if
  import aes_mix_pkg::*;
  ();

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] Shift_Text;
  logic               in_bypass;
`ifdef MIXCOL_INV_EN
  logic               in_inv;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] Mix_Text;
  logic               busy;

  modport master (
`ifdef MIXCOL_INV_EN
    output in_inv,
`endif
    output in_valid, Shift_Text, in_bypass, out_ready,
    input  in_ready, out_valid, Mix_Text, busy
  );

  modport slave (
`ifdef MIXCOL_INV_EN
    input  in_inv,
`endif
    input  in_valid, Shift_Text, in_bypass, out_ready,
    output in_ready, out_valid, Mix_Text, busy
  );

endinterface

// File: rtl/mixcol_seq_mix_column32.sv
// Purpose: one-column AES MixColumns (forward; inverse too when MIXCOL_INV_EN is defined).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: col_in (32b, row-0 byte in MSBs), inv (MIXCOL_INV_EN only), col_out (32b).
module mix_column32
  import aes_mix_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
`ifdef MIXCOL_INV_EN
  input  logic             inv,
`endif
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] k0, k1, k2, k3;

  assign {a0, a1, a2, a3} = col_in;

  // First row of the circulant matrix; later rows are the same row rotated right.
  always_comb begin
    k0 = 8'h02;
    k1 = 8'h03;
    k2 = 8'h01;
    k3 = 8'h01;
`ifdef MIXCOL_INV_EN
    if (inv) begin
      k0 = 8'h0E;
      k1 = 8'h0B;
      k2 = 8'h0D;
      k3 = 8'h09;
    end
`endif
  end

  assign col_out[31:24] = gf_mul(a0, k0) ^ gf_mul(a1, k1) ^ gf_mul(a2, k2) ^ gf_mul(a3, k3);
  assign col_out[23:16] = gf_mul(a0, k3) ^ gf_mul(a1, k0) ^ gf_mul(a2, k1) ^ gf_mul(a3, k2);
  assign col_out[15:8]  = gf_mul(a0, k2) ^ gf_mul(a1, k3) ^ gf_mul(a2, k0) ^ gf_mul(a3, k1);
  assign col_out[7:0]   = gf_mul(a0, k1) ^ gf_mul(a1, k2) ^ gf_mul(a2, k3) ^ gf_mul(a3, k0);

endmodule

// File: rtl/mixcol_seq.sv
// Purpose: column-serial MixColumns sequencer; one shared column mixer, one column per cycle.
// Latency: mixed block spends 4 cycles in RUN before out_valid; bypass block is valid the cycle after accept.
// Backpressure: result held in DONE until out_ready; in_ready low in RUN and in DONE without out_ready.
// Ports: clk, rst (sync, active high), bus (mixcol_seq_if.slave). Optional MIXCOL_INV_EN adds in_inv.
module mixcol_seq
  import aes_mix_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mixcol_seq_if.slave bus
);

  mix_state_e         state, state_nxt;
  logic [1:0]         col_cnt;
  logic [STATE_W-1:0] in_reg;
  logic [STATE_W-1:0] out_reg;
  logic [6:0]         col_msb;
  logic [COL_W-1:0]   col_in;
  logic [COL_W-1:0]   col_out;
  logic               in_rdy;
  logic               accept;
`ifdef MIXCOL_INV_EN
  logic               inv_q;
`endif

  // Column c sits at bits [127-32c -: 32].
  assign col_msb = 7'd127 - {col_cnt, 5'd0};
  assign col_in  = in_reg[col_msb -: COL_W];

  // Ready in DONE only when the held result leaves on the same edge.
  assign in_rdy = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept = bus.in_valid & in_rdy;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == DONE);
  assign bus.Mix_Text  = out_reg;
  assign bus.busy      = (state != IDLE);

  mix_column32 u_mix (
    .col_in  (col_in),
`ifdef MIXCOL_INV_EN
    .inv     (inv_q),
`endif
    .col_out (col_out)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = bus.in_bypass ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (col_cnt == 2'd3) state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      in_reg  <= '0;
      out_reg <= '0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        in_reg  <= bus.Shift_Text;
        col_cnt <= 2'd0;
`ifdef MIXCOL_INV_EN
        inv_q   <= bus.in_inv;
`endif
        // Bypass fills the whole result at once, so the mixer result is never used.
        if (bus.in_bypass) out_reg <= bus.Shift_Text;
      end else if (state == RUN) begin
        out_reg[col_msb -: COL_W] <= col_out;
        col_cnt                   <= col_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// Purpose: self-checking bench for mixcol_seq with a scoreboard of expected results.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready hold, burst and reset-abort cases.
module tb_mixcol_seq;
  import aes_mix_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   acc_cyc;
  int   n_chk;
  int   n_fail;
  logic [STATE_W-1:0] sb_q[$];
  logic [STATE_W-1:0] sb_exp;

  mixcol_seq_if bus ();

  mixcol_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [STATE_W-1:0] got, input logic [STATE_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written from the matrix definition with xtime expansions.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic inv);
    logic [7:0] a [4];
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      x1[i] = xt(a[i]);
      x2[i] = xt(x1[i]);
      x3[i] = xt(x2[i]);
      m9[i] = x3[i] ^ a[i];
      mb[i] = x3[i] ^ x1[i] ^ a[i];
      md[i] = x3[i] ^ x2[i] ^ a[i];
      me[i] = x3[i] ^ x2[i] ^ x1[i];
    end
    if (inv)
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    return {x1[0] ^ (x1[1] ^ a[1]) ^ a[2] ^ a[3],
            a[0] ^ x1[1] ^ (x1[2] ^ a[2]) ^ a[3],
            a[0] ^ a[1] ^ x1[2] ^ (x1[3] ^ a[3]),
            (x1[0] ^ a[0]) ^ a[1] ^ a[2] ^ x1[3]};
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    return {ref_col(s[127:96], inv), ref_col(s[95:64], inv),
            ref_col(s[63:32], inv), ref_col(s[31:0], inv)};
  endfunction

  logic inv_sel;
`ifdef MIXCOL_INV_EN
  assign inv_sel = bus.in_inv;
`else
  assign inv_sel = 1'b0;
`endif

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra_output", 128'd1, 128'd0);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_data", bus.Mix_Text, sb_exp);
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(bus.in_bypass ? bus.Shift_Text : ref_mix(bus.Shift_Text, inv_sel));
    end
  end

  task automatic drive(input logic [127:0] d, input logic byp, input logic inv);
    bus.in_valid   = 1'b1;
    bus.Shift_Text = d;
    bus.in_bypass  = byp;
`ifdef MIXCOL_INV_EN
    bus.in_inv     = inv;
`else
    if (inv) $display("note: inverse request ignored in forward-only build");
`endif
  endtask

  // Returns #1 after the accept edge; acc_cyc holds the cycle of the handshake.
  task automatic send(input logic [127:0] d, input logic byp, input logic inv);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    drive(d, byp, inv);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc_cyc = cyc;
        ok = 1;
      end
    end
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits on negedges for out_valid; diff = cycles from handshake cycle to first valid cycle.
  task automatic wait_out(output int diff);
    bit ok;
    ok   = 0;
    diff = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        diff = cyc - acc_cyc;
        ok   = 1;
      end
    end
    if (!ok) chk("out_timeout", 128'd0, 128'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [127:0] d, x, y;
    int diff;
    n_chk  = 0;
    n_fail = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.Shift_Text = '0;
    bus.in_bypass  = 1'b0;
    bus.out_ready  = 1'b1;
`ifdef MIXCOL_INV_EN
    bus.in_inv     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mix_text", bus.Mix_Text, 0);

    // Single repeated column; mixed block spends 4 cycles in RUN.
    send({4{32'hdb135345}}, 1'b0, 1'b0);
    wait_out(diff);
    chk("col_run_cycles", diff - 1, 4);
    chk("col_data", bus.Mix_Text, {4{32'h8e4da1bc}});

    // FIPS-197 round 1 state.
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0);
    wait_out(diff);
    chk("fips_data", bus.Mix_Text, 128'h046681e5e0cb199a48f8d37a2806264c);

    // Single bypass block: valid in the cycle after accept.
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b1, 1'b1);
    wait_out(diff);
    chk("byp_latency", diff, 1);
    chk("byp_data", bus.Mix_Text, d);

    // Four bypass blocks back to back with out_ready high.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive({4{$urandom}}, 1'b1, 1'b0);
      @(negedge clk);
      chk("burst_in_ready", bus.in_ready, 1);
      if (i > 0) chk("burst_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("burst_last_valid", bus.out_valid, 1);
    @(negedge clk);
    chk("burst_drained", bus.out_valid, 0);

    // Backpressure: hold DONE for 10 cycles with a new block waiting.
    bus.out_ready = 1'b0;
    x = {$urandom, $urandom, $urandom, $urandom};
    y = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, 1'b0);
    drive(y, 1'b0, 1'b0);
    wait_out(diff);
    chk("bp_run_cycles", diff - 1, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", bus.Mix_Text, ref_mix(x, 1'b0));
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_busy", bus.busy, 1);
    chk("bp_new_not_valid", bus.out_valid, 0);
    wait_out(diff);
    chk("bp_new_run_cycles", diff - 1, 4);
    chk("bp_new_data", bus.Mix_Text, ref_mix(y, 1'b0));

    // Reset after 2 RUN cycles discards the block.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstrun_out_valid", bus.out_valid, 0);
    chk("rstrun_in_ready", bus.in_ready, 1);
    chk("rstrun_busy", bus.busy, 0);
    send({4{32'h01010101}}, 1'b0, 1'b0);
    wait_out(diff);
    chk("rstrun_next_data", bus.Mix_Text, {4{32'h01010101}});

    // Random mixed and bypass blocks, checked by the scoreboard.
    for (int i = 0; i < 6; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      wait_out(diff);
    end

`ifdef MIXCOL_INV_EN
    send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b1);
    wait_out(diff);
    chk("inv_fips_data", bus.Mix_Text, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
`endif

    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
